// File: rtl/ppu_mem_pkg.sv
// ppu_mem_pkg: size encodings, arbiter FSM states and beats-per-size helper for mem_port_arbiter
package ppu_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  function automatic logic [2:0] beats(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: cpu-priority grant with starvation override for dbg (clk, reset, idle, cpu_req, dbg_req -> gnt_cpu, gnt_dbg)
module mem_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic gnt_cpu,
  output logic gnt_dbg
);
  localparam int CW = $clog2(STARVE_MAX + 2);
  logic [CW-1:0] starve_cnt;
  logic starved;
  always_comb begin
    starved = starve_cnt == CW'(STARVE_MAX);
    gnt_dbg = idle && dbg_req && (!cpu_req || starved);
    gnt_cpu = idle && cpu_req && !gnt_dbg;
  end
  always_ff @(posedge clk) begin
    if (reset) starve_cnt <= '0;
    else starve_cnt <= (!dbg_req || gnt_dbg) ? '0 : (gnt_cpu && !starved) ? starve_cnt + 1'b1 : starve_cnt;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: cpu/dbg requests -> big-endian byte-serial RAM port (ram_addr/we/wdata/rdata), ack/err/rdata per requester, cpu_stall; macro MEM_ARB_ALIGN_CHECK_EN enables misalignment errors
module mem_port_arbiter
  import ppu_mem_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  state_t state;
  logic gnt_cpu, gnt_dbg, sel_dbg, we_q, xfer, bad, g_we;
  logic [1:0] beat, g_size, g_sz;
  logic [2:0] n_q, g_n;
  logic [ADDR_W-1:0] base, g_addr, g_base;
  logic [31:0] sh, asm_q, g_wdata, ld;
  mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk     (clk),
    .reset   (reset),
    .idle    (state == IDLE),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .gnt_cpu (gnt_cpu),
    .gnt_dbg (gnt_dbg)
  );
  always_comb begin
    g_we = gnt_dbg ? dbg_we : cpu_we;
    g_size = gnt_dbg ? dbg_size : cpu_size;
    g_addr = gnt_dbg ? dbg_addr : cpu_addr;
    g_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    g_sz = g_size;
    g_base = g_addr;
    bad = g_size == 2'b11 || (g_size == SZ_HALF && g_addr[0]) || (g_size == SZ_WORD && g_addr[1:0] != 2'b00);
`else
    g_sz = g_size == 2'b11 ? SZ_WORD : g_size;
    g_base = g_sz == SZ_BYTE ? g_addr : g_sz == SZ_HALF ? {g_addr[ADDR_W-1:1], 1'b0} : {g_addr[ADDR_W-1:2], 2'b00};
    bad = 1'b0;
`endif
    g_n = beats(g_sz);
    ld = {asm_q[23:0], ram_rdata};
    xfer = state == XFER && !reset;
    ram_addr = xfer ? base + ADDR_W'(beat) : '0;
    ram_we = xfer && we_q;
    ram_wdata = ram_we ? sh[31:24] : 8'h00;
    cpu_stall = cpu_req && !cpu_ack;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      cpu_err <= 1'b0;
      dbg_err <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      sel_dbg <= 1'b0;
      we_q <= 1'b0;
      n_q <= '0;
      beat <= '0;
      base <= '0;
      sh <= '0;
      asm_q <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      cpu_err <= 1'b0;
      dbg_err <= 1'b0;
      case (state)
        IDLE: if (gnt_cpu || gnt_dbg) begin
          sel_dbg <= gnt_dbg;
          we_q <= g_we;
          n_q <= g_n;
          base <= g_base;
          sh <= g_wdata << {3'd4 - g_n, 3'b000};
          asm_q <= '0;
          beat <= '0;
          state <= bad ? RESP : XFER;
          cpu_ack <= bad && gnt_cpu;
          dbg_ack <= bad && gnt_dbg;
          cpu_err <= bad && gnt_cpu;
          dbg_err <= bad && gnt_dbg;
        end
        XFER: begin
          asm_q <= ld;
          sh <= sh << 8;
          beat <= beat + 2'd1;
          if (beat == 2'(n_q - 3'd1)) begin
            state <= RESP;
            cpu_ack <= !sel_dbg;
            dbg_ack <= sel_dbg;
            if (!we_q && !sel_dbg) cpu_rdata <= ld;
            if (!we_q && sel_dbg) dbg_rdata <= ld;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a byte RAM model
module tb_mem_port_arbiter;
  import ppu_mem_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [1:0] cpu_size = 0, dbg_size = 0;
  logic [8:0] cpu_addr = 0, dbg_addr = 0;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, ram_we;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] mem [512];
  int we_cnt = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] cpu_rd = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  logic [7:0] gq[$];
  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) begin
    mem[ram_addr] <= ram_wdata;
    we_cnt <= we_cnt + 1;
  end
  mem_port_arbiter #(.ADDR_W(9), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  task automatic run_xfer(input bit dbg, input bit we, input logic [1:0] size, input logic [8:0] addr, input logic [31:0] wdata, input bit drop, output int lat, output logic [31:0] rd, output logic er, output bit stall_ok);
    stall_ok = 1;
    lat = -1;
    rd = 'x;
    er = 'x;
    if (dbg) begin
      dbg_we = we; dbg_size = size; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1;
    end else begin
      cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1;
    end
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (!dbg && !drop && cpu_stall !== 1'b1) stall_ok = 0;
      @(posedge clk);
      #1;
      if (drop) begin cpu_req = 0; dbg_req = 0; end
      if (dbg ? dbg_ack : cpu_ack) begin
        lat = i;
        rd = dbg ? dbg_rdata : cpu_rdata;
        er = dbg ? dbg_err : cpu_err;
        if (!dbg && !drop && cpu_stall !== 1'b0) stall_ok = 0;
        break;
      end
    end
    cpu_req = 0;
    dbg_req = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    n_chk++;
    if ({cpu_ack, dbg_ack, cpu_err, dbg_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {cpu_ack, dbg_ack, cpu_err, dbg_err}); end
    n_chk++;
    if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
    n_chk++;
    if (ram_addr !== 9'h0 || ram_we !== 1'b0 || ram_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_ram: got addr=%h we=%b wd=%h want 0", ram_addr, ram_we, ram_wdata); end
    n_chk++;
    if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
  endtask
  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er; bit sok; exp_t e;
    logic [7:0] bytes_exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sb.push_back('{rdata: cpu_rd, err: 1'b0, lat: 5});
    run_xfer(0, 1, SZ_WORD, 9'd56, 32'hDEADBEEF, 0, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL word_store: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    n_chk++;
    if (!sok) begin n_fail++; $display("FAIL word_store_stall: got stall profile wrong want high cycles 0-4 low at ack"); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (mem[56+k] !== bytes_exp[k]) begin n_fail++; $display("FAIL word_store_ram[%0d]: got %h want %h", 56 + k, mem[56+k], bytes_exp[k]); end
    end
  endtask
  task automatic test_loads();
    int lat; logic [31:0] rd; logic er; bit sok; exp_t e;
    logic [1:0] sz [4] = '{SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BYTE};
    logic [8:0] ad [4] = '{9'd57, 9'd58, 9'd56, 9'd59};
    logic [31:0] ex [4] = '{32'h000000AD, 32'h0000BEEF, 32'hDEADBEEF, 32'h000000EF};
    int lt [4] = '{2, 3, 5, 2};
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{rdata: ex[k], err: 1'b0, lat: lt[k]});
      run_xfer(0, 0, sz[k], ad[k], 32'h0, 0, lat, rd, er, sok);
      e = sb.pop_front();
      cpu_rd = e.rdata;
      n_chk++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err || !sok) begin n_fail++; $display("FAIL load%0d: got lat=%0d rd=%h err=%b stall_ok=%0d want lat=%0d rd=%h err=%b", k, lat, rd, er, sok, e.lat, e.rdata, e.err); end
    end
  endtask
  task automatic test_stores();
    int lat; logic [31:0] rd; logic er; bit sok; exp_t e;
    sb.push_back('{rdata: cpu_rd, err: 1'b0, lat: 2});
    run_xfer(0, 1, SZ_BYTE, 9'd100, 32'hFFFFFF5A, 0, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL byte_store: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    n_chk++;
    if (mem[100] !== 8'h5A) begin n_fail++; $display("FAIL byte_store_ram: got %h want 5a", mem[100]); end
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
    run_xfer(1, 1, SZ_HALF, 9'd102, 32'h00001234, 0, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL dbg_half_store: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    sb.push_back('{rdata: 32'h00001234, err: 1'b0, lat: 3});
    run_xfer(1, 0, SZ_HALF, 9'd102, 32'h0, 0, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL dbg_half_load: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    n_chk++;
    if (cpu_rdata !== cpu_rd) begin n_fail++; $display("FAIL cpu_rdata_hold: got %h want %h", cpu_rdata, cpu_rd); end
  endtask
  task automatic test_misaligned();
    int lat, w0; logic [31:0] rd; logic er; bit sok; exp_t e;
    sb.push_back('{rdata: 32'h000000AD, err: 1'b0, lat: 2});
    run_xfer(0, 0, SZ_BYTE, 9'd57, 32'h0, 0, lat, rd, er, sok);
    e = sb.pop_front();
    cpu_rd = e.rdata;
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL pre_byte_load: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    for (int k = 0; k < 2; k++) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
      sb.push_back('{rdata: cpu_rd, err: 1'b1, lat: 1});
`else
      sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 5});
`endif
      run_xfer(0, 0, k == 0 ? SZ_WORD : 2'b11, k == 0 ? 9'd58 : 9'd56, 32'h0, 0, lat, rd, er, sok);
      e = sb.pop_front();
      cpu_rd = e.rdata;
      n_chk++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL odd_load%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", k, lat, rd, er, e.lat, e.rdata, e.err); end
    end
    w0 = we_cnt;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    sb.push_back('{rdata: cpu_rd, err: 1'b1, lat: 1});
`else
    sb.push_back('{rdata: cpu_rd, err: 1'b0, lat: 3});
`endif
    run_xfer(0, 1, SZ_HALF, 9'd201, 32'h0000CAFE, 0, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL odd_store: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
`ifdef MEM_ARB_ALIGN_CHECK_EN
    n_chk++;
    if (we_cnt !== w0) begin n_fail++; $display("FAIL odd_store_no_ram: got %0d writes want 0", we_cnt - w0); end
`else
    n_chk++;
    if (mem[200] !== 8'hCA || mem[201] !== 8'hFE) begin n_fail++; $display("FAIL odd_store_ram: got %h %h want ca fe", mem[200], mem[201]); end
`endif
  endtask
  task automatic test_req_drop();
    int lat; logic [31:0] rd; logic er; bit sok; exp_t e;
    sb.push_back('{rdata: cpu_rd, err: 1'b0, lat: 3});
    run_xfer(0, 1, SZ_HALF, 9'd120, 32'h00007788, 1, lat, rd, er, sok);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL req_drop: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b", lat, rd, er, e.lat, e.rdata, e.err); end
    n_chk++;
    if (mem[120] !== 8'h77 || mem[121] !== 8'h88) begin n_fail++; $display("FAIL req_drop_ram: got %h %h want 77 88", mem[120], mem[121]); end
  endtask
  task automatic test_starve();
    int got = 0;
    logic [7:0] e, a;
    gq = '{"C", "C", "C", "C", "D", "C"};
    cpu_we = 0; cpu_size = SZ_BYTE; cpu_addr = 9'd57;
    dbg_we = 0; dbg_size = SZ_BYTE; dbg_addr = 9'd56;
    cpu_req = 1;
    dbg_req = 1;
    for (int i = 0; i < 200 && got < 6; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || dbg_ack) begin
        e = gq.pop_front();
        a = dbg_ack ? "D" : "C";
        n_chk++;
        if (a !== e) begin n_fail++; $display("FAIL grant_order[%0d]: got %s want %s", got, a, e); end
        if (dbg_ack) begin
          n_chk++;
          if (dut.u_grant.starve_cnt !== '0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.u_grant.starve_cnt); end
        end
        got++;
      end
    end
    if (got < 6) begin n_chk++; n_fail++; $display("FAIL starve_timeout: got %0d acks want 6", got); end
    cpu_req = 0;
    dbg_req = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid_xfer();
    bit any_ack = 0;
    for (int k = 64; k < 68; k++) mem[k] = 8'hAA;
    cpu_we = 1; cpu_size = SZ_WORD; cpu_addr = 9'd64; cpu_wdata = 32'h11223344;
    cpu_req = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (cpu_ack) any_ack = 1;
    end
    reset = 1;
    cpu_req = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (4) begin
      if (cpu_ack || dbg_ack) any_ack = 1;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (mem[64] !== 8'h11 || mem[65] !== 8'h22) begin n_fail++; $display("FAIL abort_written: got %h %h want 11 22", mem[64], mem[65]); end
    n_chk++;
    if (mem[66] !== 8'hAA || mem[67] !== 8'hAA) begin n_fail++; $display("FAIL abort_untouched: got %h %h want aa aa", mem[66], mem[67]); end
    n_chk++;
    if (any_ack) begin n_fail++; $display("FAIL abort_no_ack: got ack=1 want 0"); end
    n_chk++;
    if (dut.state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want IDLE", dut.state); end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    test_reset();
    test_word_store();
    test_loads();
    test_stores();
    test_misaligned();
    test_req_drop();
    test_starve();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
